// File: rtl/operand_fetch_pkg.sv
// Shared core definitions for the operand fetch slice: datapath width,
// register index width and the write-snoop match rule used by every bypass.
package operand_fetch_pkg;

  localparam int unsigned CORE_XLEN = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // A snooped register-file write is relevant to a source only when it
  // targets the same nonzero index; x0 is hardwired to zero.
  function automatic logic wr_hits(input logic     wr_valid,
                                   input reg_idx_t wr_addr,
                                   input reg_idx_t idx);
    return wr_valid && (wr_addr == idx) && (idx != '0);
  endfunction

endpackage

// File: rtl/operand_fetch_bypass.sv
// Forwarding compare/mux for one source operand in one pipeline stage.
// Priority: x0 -> zero, live snooped write -> previously captured forward
// data -> base data (register-file read data or the held stage value).
module operand_bypass
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN = CORE_XLEN
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 wr_valid,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 fwd_valid,
  input  logic [XLEN-1:0]      fwd_data,
  input  logic [XLEN-1:0]      base_data,
  output logic                 hit,
  output logic [XLEN-1:0]      operand
);

  // Resolve the operand value for this source
  always_comb begin
    hit = wr_hits(wr_valid, wr_addr, idx);
    if (idx == '0) begin
      operand = '0;
    end else if (hit) begin
      operand = wr_data;
    end else if (fwd_valid) begin
      operand = fwd_data;
    end else begin
      operand = base_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Two-stage operand fetch between decode and execute.
// S1 holds the instruction while its register-file read is in flight and
// captures any snooped writes that arrive after the read was issued.
// S2 is the output register toward execute and keeps tracking writes to its
// sources while execute back-pressures.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN = CORE_XLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  // decode handshake
  input  logic                 i_dec_valid,
  output logic                 o_dec_ready,
  input  logic [REG_IDX_W-1:0] i_dec_rs1,
  input  logic [REG_IDX_W-1:0] i_dec_rs2,
  input  logic [REG_IDX_W-1:0] i_dec_rd,
  input  logic [XLEN-1:0]      i_dec_imm,
  input  logic [XLEN-1:0]      i_dec_pc,
  // register-file read port
  output logic                 o_rs_ren,
  output logic [REG_IDX_W-1:0] o_rs1_raddr,
  output logic [REG_IDX_W-1:0] o_rs2_raddr,
  input  logic [XLEN-1:0]      i_rs1_rdata,
  input  logic [XLEN-1:0]      i_rs2_rdata,
  // register-file write snoop
  input  logic                 i_rd_wvalid,
  input  logic [REG_IDX_W-1:0] i_rd_waddr,
  input  logic [XLEN-1:0]      i_rd_wdata,
  // execute handshake
  output logic                 o_op_valid,
  input  logic                 i_op_ready,
  output logic [XLEN-1:0]      o_op_rs1_data,
  output logic [XLEN-1:0]      o_op_rs2_data,
  output logic [REG_IDX_W-1:0] o_op_rd,
  output logic [XLEN-1:0]      o_op_imm,
  output logic [XLEN-1:0]      o_op_pc
);

  // pipeline control
  logic s1_adv;
  logic accept;
  logic s2_hold;

  // S1: instruction metadata and forward registers
  logic            s1_valid;
  reg_idx_t        s1_rs1;
  reg_idx_t        s1_rs2;
  reg_idx_t        s1_rd;
  logic [XLEN-1:0] s1_imm;
  logic [XLEN-1:0] s1_pc;
  logic            s1_fwd1_valid;
  logic            s1_fwd2_valid;
  logic [XLEN-1:0] s1_fwd1_data;
  logic [XLEN-1:0] s1_fwd2_data;

  // S1 resolved operands
  logic            s1_hit1;
  logic            s1_hit2;
  logic [XLEN-1:0] s1_op1;
  logic [XLEN-1:0] s1_op2;

  // S2 source indices, kept so held operands can keep tracking writes
  reg_idx_t        s2_rs1;
  reg_idx_t        s2_rs2;
  logic            s2_hit1;
  logic            s2_hit2;
  logic [XLEN-1:0] s2_op1;
  logic [XLEN-1:0] s2_op2;

  // Handshake and read-port control
  always_comb begin
    s1_adv      = !o_op_valid || i_op_ready;
    o_dec_ready = !s1_valid || s1_adv;
    accept      = i_dec_valid && o_dec_ready;
    s2_hold     = o_op_valid && !i_op_ready;
    o_rs_ren    = accept;
    o_rs1_raddr = i_dec_rs1;
    o_rs2_raddr = i_dec_rs2;
  end

  // S1 bypass: live write on the transfer edge is folded in combinationally
  operand_bypass #(.XLEN(XLEN)) u_s1_byp_rs1 (
    .idx       (s1_rs1),
    .wr_valid  (i_rd_wvalid),
    .wr_addr   (i_rd_waddr),
    .wr_data   (i_rd_wdata),
    .fwd_valid (s1_fwd1_valid),
    .fwd_data  (s1_fwd1_data),
    .base_data (i_rs1_rdata),
    .hit       (s1_hit1),
    .operand   (s1_op1)
  );

  operand_bypass #(.XLEN(XLEN)) u_s1_byp_rs2 (
    .idx       (s1_rs2),
    .wr_valid  (i_rd_wvalid),
    .wr_addr   (i_rd_waddr),
    .wr_data   (i_rd_wdata),
    .fwd_valid (s1_fwd2_valid),
    .fwd_data  (s1_fwd2_data),
    .base_data (i_rs2_rdata),
    .hit       (s1_hit2),
    .operand   (s1_op2)
  );

  // S2 bypass: only writes seen while execute is stalling update the output
  operand_bypass #(.XLEN(XLEN)) u_s2_byp_rs1 (
    .idx       (s2_rs1),
    .wr_valid  (i_rd_wvalid && s2_hold),
    .wr_addr   (i_rd_waddr),
    .wr_data   (i_rd_wdata),
    .fwd_valid (1'b0),
    .fwd_data  ('0),
    .base_data (o_op_rs1_data),
    .hit       (s2_hit1),
    .operand   (s2_op1)
  );

  operand_bypass #(.XLEN(XLEN)) u_s2_byp_rs2 (
    .idx       (s2_rs2),
    .wr_valid  (i_rd_wvalid && s2_hold),
    .wr_addr   (i_rd_waddr),
    .wr_data   (i_rd_wdata),
    .fwd_valid (1'b0),
    .fwd_data  ('0),
    .base_data (o_op_rs2_data),
    .hit       (s2_hit2),
    .operand   (s2_op2)
  );

  // S1 load on accept; while stalled, capture writes the stale read missed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_rs1        <= '0;
      s1_rs2        <= '0;
      s1_rd         <= '0;
      s1_imm        <= '0;
      s1_pc         <= '0;
      s1_fwd1_valid <= 1'b0;
      s1_fwd2_valid <= 1'b0;
      s1_fwd1_data  <= '0;
      s1_fwd2_data  <= '0;
    end else if (o_dec_ready) begin
      s1_valid <= i_dec_valid;
      if (i_dec_valid) begin
        s1_rs1        <= i_dec_rs1;
        s1_rs2        <= i_dec_rs2;
        s1_rd         <= i_dec_rd;
        s1_imm        <= i_dec_imm;
        s1_pc         <= i_dec_pc;
        // the register file returns the pre-write value for a same-cycle write
        s1_fwd1_valid <= wr_hits(i_rd_wvalid, i_rd_waddr, i_dec_rs1);
        s1_fwd2_valid <= wr_hits(i_rd_wvalid, i_rd_waddr, i_dec_rs2);
        s1_fwd1_data  <= i_rd_wdata;
        s1_fwd2_data  <= i_rd_wdata;
      end
    end else begin
      if (s1_hit1) begin
        s1_fwd1_valid <= 1'b1;
        s1_fwd1_data  <= i_rd_wdata;
      end
      if (s1_hit2) begin
        s1_fwd2_valid <= 1'b1;
        s1_fwd2_data  <= i_rd_wdata;
      end
    end
  end

  // S2 output register: transfer from S1, or track writes while held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_op_valid    <= 1'b0;
      o_op_rs1_data <= '0;
      o_op_rs2_data <= '0;
      o_op_rd       <= '0;
      o_op_imm      <= '0;
      o_op_pc       <= '0;
      s2_rs1        <= '0;
      s2_rs2        <= '0;
    end else if (s1_adv) begin
      o_op_valid <= s1_valid;
      if (s1_valid) begin
        o_op_rs1_data <= s1_op1;
        o_op_rs2_data <= s1_op2;
        o_op_rd       <= s1_rd;
        o_op_imm      <= s1_imm;
        o_op_pc       <= s1_pc;
        s2_rs1        <= s1_rs1;
        s2_rs2        <= s1_rs2;
      end
    end else begin
      if (s2_hit1) begin
        o_op_rs1_data <= s2_op1;
      end
      if (s2_hit2) begin
        o_op_rs2_data <= s2_op2;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by randomized traffic.
// Expected operands come from an architectural register model: an operand
// must equal its register's value as of the cycle the instruction leaves.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int SB_DEPTH = 1024;

  logic            clk;
  logic            rst;
  logic            i_dec_valid;
  logic            o_dec_ready;
  reg_idx_t        i_dec_rs1;
  reg_idx_t        i_dec_rs2;
  reg_idx_t        i_dec_rd;
  logic [XLEN-1:0] i_dec_imm;
  logic [XLEN-1:0] i_dec_pc;
  logic            o_rs_ren;
  reg_idx_t        o_rs1_raddr;
  reg_idx_t        o_rs2_raddr;
  logic [XLEN-1:0] i_rs1_rdata;
  logic [XLEN-1:0] i_rs2_rdata;
  logic            i_rd_wvalid;
  reg_idx_t        i_rd_waddr;
  logic [XLEN-1:0] i_rd_wdata;
  logic            o_op_valid;
  logic            i_op_ready;
  logic [XLEN-1:0] o_op_rs1_data;
  logic [XLEN-1:0] o_op_rs2_data;
  reg_idx_t        o_op_rd;
  logic [XLEN-1:0] o_op_imm;
  logic [XLEN-1:0] o_op_pc;

  int total = 0;
  int bad   = 0;

  operand_fetch #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_dec_valid   (i_dec_valid),
    .o_dec_ready   (o_dec_ready),
    .i_dec_rs1     (i_dec_rs1),
    .i_dec_rs2     (i_dec_rs2),
    .i_dec_rd      (i_dec_rd),
    .i_dec_imm     (i_dec_imm),
    .i_dec_pc      (i_dec_pc),
    .o_rs_ren      (o_rs_ren),
    .o_rs1_raddr   (o_rs1_raddr),
    .o_rs2_raddr   (o_rs2_raddr),
    .i_rs1_rdata   (i_rs1_rdata),
    .i_rs2_rdata   (i_rs2_rdata),
    .i_rd_wvalid   (i_rd_wvalid),
    .i_rd_waddr    (i_rd_waddr),
    .i_rd_wdata    (i_rd_wdata),
    .o_op_valid    (o_op_valid),
    .i_op_ready    (i_op_ready),
    .o_op_rs1_data (o_op_rs1_data),
    .o_op_rs2_data (o_op_rs2_data),
    .o_op_rd       (o_op_rd),
    .o_op_imm      (o_op_imm),
    .o_op_pc       (o_op_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input logic [XLEN-1:0] act,
                              input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  // Environment register file: registered read, writes land at the edge,
  // and x0 really stores whatever is written so it can hold garbage.
  logic [XLEN-1:0] rf [32];
  always @(posedge clk) begin
    if (i_rd_wvalid) rf[i_rd_waddr] <= i_rd_wdata;
    if (o_rs_ren) begin
      i_rs1_rdata <= rf[o_rs1_raddr];
      i_rs2_rdata <= rf[o_rs2_raddr];
    end
  end

  // Reference architectural state: x0 is never written
  logic [XLEN-1:0] arch [32];
  always @(posedge clk) begin
    if (i_rd_wvalid && i_rd_waddr != 5'd0) arch[i_rd_waddr] <= i_rd_wdata;
  end

  function automatic logic [XLEN-1:0] arch_val(input reg_idx_t idx);
    return (idx == 5'd0) ? '0 : arch[idx];
  endfunction

  // Scoreboard ring of accepted instructions
  typedef struct packed {
    reg_idx_t        rs1;
    reg_idx_t        rs2;
    reg_idx_t        rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } txn_t;

  txn_t sb [SB_DEPTH];
  int   wr_ptr = 0;
  int   rd_ptr = 0;

  // Push: an instruction is accepted at the coming edge
  always @(negedge clk) begin
    if (!rst && i_dec_valid && o_dec_ready) begin
      sb[wr_ptr % SB_DEPTH] = '{rs1: i_dec_rs1, rs2: i_dec_rs2, rd: i_dec_rd,
                                imm: i_dec_imm, pc: i_dec_pc};
      wr_ptr++;
    end
  end

  // Monitor: an instruction is consumed at the coming edge
  always @(negedge clk) begin
    txn_t t;
    if (rst) begin
      rd_ptr = wr_ptr;
    end else if (o_op_valid && i_op_ready) begin
      chk("sb_expected_output", 32'(rd_ptr != wr_ptr), 32'd1);
      if (rd_ptr != wr_ptr) begin
        t = sb[rd_ptr % SB_DEPTH];
        rd_ptr++;
        chk("sb_rs1", o_op_rs1_data, arch_val(t.rs1));
        chk("sb_rs2", o_op_rs2_data, arch_val(t.rs2));
        chk("sb_rd",  32'(o_op_rd), 32'(t.rd));
        chk("sb_imm", o_op_imm, t.imm);
        chk("sb_pc",  o_op_pc, t.pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input reg_idx_t rs1, input reg_idx_t rs2,
                         input reg_idx_t rd, input logic [XLEN-1:0] pc);
    i_dec_valid = 1'b1;
    i_dec_rs1   = rs1;
    i_dec_rs2   = rs2;
    i_dec_rd    = rd;
    i_dec_imm   = $urandom;
    i_dec_pc    = pc;
  endtask

  logic acc;
  int   k;

  initial begin
    rst         = 1'b1;
    i_dec_valid = 1'b0;
    i_dec_rs1   = '0;
    i_dec_rs2   = '0;
    i_dec_rd    = '0;
    i_dec_imm   = '0;
    i_dec_pc    = '0;
    i_rd_wvalid = 1'b0;
    i_rd_waddr  = '0;
    i_rd_wdata  = '0;
    i_op_ready  = 1'b1;

    // preload the register file while the block is in reset
    for (int i = 0; i < 32; i++) begin
      step();
      i_rd_wvalid = 1'b1;
      i_rd_waddr  = reg_idx_t'(i);
      i_rd_wdata  = (i == 0) ? 32'hDEAD_BEEF : $urandom;
    end
    step();
    i_rd_wvalid = 1'b0;

    @(negedge clk);
    chk("rst_op_valid", 32'(o_op_valid), 32'd0);
    chk("rst_dec_ready", 32'(o_dec_ready), 32'd1);
    chk("rst_op_rd", 32'(o_op_rd), 32'd0);
    chk("rst_op_rs1", o_op_rs1_data, 32'd0);
    chk("rst_op_pc", o_op_pc, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_dec_ready", 32'(o_dec_ready), 32'd1);

    // basic add: x1=5, x2=7
    step();
    i_rd_wvalid = 1'b1; i_rd_waddr = 5'd1; i_rd_wdata = 32'd5;
    step();
    i_rd_waddr = 5'd2; i_rd_wdata = 32'd7;
    step();
    i_rd_wvalid = 1'b0;
    set_dec(5'd1, 5'd2, 5'd3, 32'h1000);
    step();
    i_dec_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_early", 32'(o_op_valid), 32'd0);
    step();
    @(negedge clk);
    chk("lat_valid", 32'(o_op_valid), 32'd1);
    chk("add_rs1", o_op_rs1_data, 32'd5);
    chk("add_rs2", o_op_rs2_data, 32'd7);
    chk("add_rd", 32'(o_op_rd), 32'd3);

    // write to x1 in the accept cycle
    step();
    set_dec(5'd1, 5'd2, 5'd4, 32'h1004);
    i_rd_wvalid = 1'b1; i_rd_waddr = 5'd1; i_rd_wdata = 32'hAA;
    step();
    i_dec_valid = 1'b0; i_rd_wvalid = 1'b0;
    step();
    @(negedge clk);
    chk("fwd_issue_valid", 32'(o_op_valid), 32'd1);
    chk("fwd_issue_rs1", o_op_rs1_data, 32'hAA);

    // rs1 = x0 while the register file holds garbage there
    step();
    set_dec(5'd0, 5'd0, 5'd5, 32'h1008);
    step();
    i_dec_valid = 1'b0;
    step();
    @(negedge clk);
    chk("x0_rs1", o_op_rs1_data, 32'd0);
    chk("x0_rs2", o_op_rs2_data, 32'd0);

    // S2 held: write x2 updates the operand, write x0 does not
    step();
    i_op_ready = 1'b0;
    set_dec(5'd0, 5'd2, 5'd6, 32'h100C);
    step();
    i_dec_valid = 1'b0;
    step();
    i_rd_wvalid = 1'b1; i_rd_waddr = 5'd2; i_rd_wdata = 32'h55;
    @(negedge clk);
    chk("hold_valid", 32'(o_op_valid), 32'd1);
    chk("hold_rs2_before", o_op_rs2_data, 32'd7);
    step();
    i_rd_waddr = 5'd0; i_rd_wdata = 32'h77;
    @(negedge clk);
    chk("hold_fwd_rs2", o_op_rs2_data, 32'h55);
    chk("hold_rs1_zero", o_op_rs1_data, 32'd0);
    step();
    i_rd_wvalid = 1'b0;
    @(negedge clk);
    chk("x0_write_rs1", o_op_rs1_data, 32'd0);
    chk("x0_write_rs2", o_op_rs2_data, 32'h55);
    chk("x0_write_rd", 32'(o_op_rd), 32'd6);
    step();
    i_op_ready = 1'b1;
    step();
    step();

    // back-to-back issue with execute stalled for 4 cycles
    step();
    i_op_ready = 1'b0;
    k = 0;
    set_dec(5'd1, 5'd2, 5'd7, 32'h200);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      acc = i_dec_valid && o_dec_ready;
      if (cyc == 2 || cyc == 3) begin
        chk("stall_dec_ready", 32'(o_dec_ready), 32'd0);
        chk("stall_pc", o_op_pc, 32'h200);
      end
      step();
      if (cyc == 3) i_op_ready = 1'b1;
      if (acc) begin
        k++;
        if (k < 4)
          set_dec(reg_idx_t'($urandom_range(1, 3)), reg_idx_t'($urandom_range(1, 3)),
                  reg_idx_t'($urandom_range(0, 31)), 32'h200 + 32'(k) * 4);
        else
          i_dec_valid = 1'b0;
      end
    end
    chk("stall_accepted", 32'(k), 32'd4);

    // reset with both stages occupied
    step();
    i_op_ready = 1'b0;
    set_dec(5'd1, 5'd3, 5'd8, 32'h300);
    step();
    set_dec(5'd2, 5'd1, 5'd9, 32'h304);
    step();
    i_dec_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(o_op_valid), 32'd1);
    chk("pre_rst_dec_ready", 32'(o_dec_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(o_op_valid), 32'd0);
    chk("rst_async_dec_ready", 32'(o_dec_ready), 32'd1);
    step();
    step();
    rst = 1'b0;
    i_op_ready = 1'b1;
    @(negedge clk);
    chk("resume_valid", 32'(o_op_valid), 32'd0);
    chk("resume_dec_ready", 32'(o_dec_ready), 32'd1);

    // randomized traffic with heavy register reuse
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = i_dec_valid && o_dec_ready;
      step();
      if (!i_dec_valid || acc) begin
        if ($urandom_range(0, 3) != 0)
          set_dec(reg_idx_t'($urandom_range(0, 3)), reg_idx_t'($urandom_range(0, 3)),
                  reg_idx_t'($urandom_range(0, 31)), $urandom);
        else
          i_dec_valid = 1'b0;
      end
      i_rd_wvalid = ($urandom_range(0, 1) == 1);
      i_rd_waddr  = reg_idx_t'($urandom_range(0, 3));
      i_rd_wdata  = $urandom;
      i_op_ready  = ($urandom_range(0, 3) != 0);
    end

    // drain with a bounded wait
    i_dec_valid = 1'b0;
    i_rd_wvalid = 1'b0;
    i_op_ready  = 1'b1;
    for (int w = 0; w < 20; w++) begin
      step();
      if (rd_ptr == wr_ptr && !o_op_valid) break;
    end
    chk("drain_empty", 32'(rd_ptr == wr_ptr), 32'd1);
    chk("drain_valid", 32'(o_op_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
